nibble_add_arbiter: RTL and testbench

Shares one registered nibble adder among `N_REQ` requesters through a round-robin arbiter with valid/ready handshakes. It accepts one operand pair at a time and drives the shared adder. It then holds the result, tagged with the requester id, until the consumer takes it. It sits between the tile's input decode logic and the output register stage. It replaces the single fixed adder path with a sequenced, shared resource.

---
 rtl/nibble_add_arbiter_pkg.sv | 19 +
 rtl/nibble_add_arbiter_if.sv | 33 +++
 rtl/nibble_add_arbiter_adder_unit.sv | 26 ++
 rtl/nibble_add_arbiter.sv | 113 +++++++++++
 tb/tb_nibble_add_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_arbiter_pkg.sv
// Shared types and constants for the round-robin nibble adder arbiter.
// Imported by the interface, the adder unit and the top.
package nibble_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arbStateT;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_W     = 4;

    // A single requester would still need one bit to carry its id.
    function automatic int idWidth(input int nReq);
        return (nReq > 1) ? $clog2(nReq) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_arbiter_if.sv
// Requester and consumer handshake bundle for nibble_add_arbiter.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface nibble_add_arbiter_if
    import nibble_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int W     = DEFAULT_W
);

    localparam int ID_W = idWidth(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [W-1:0]       rsp_sum;
    logic               rsp_carry;
    logic [7:0]         op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, op_count
    );

endinterface

// File: rtl/nibble_add_arbiter_adder_unit.sv
// Registered W-bit adder producing a W+1-bit result.
// It loads on every clock edge while its enable is high.
module nibble_adder_unit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   sum_o
);

    logic [W:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter that shares one registered adder among N_REQ requesters.
// The result is held, tagged with the owner's id, until the consumer takes it.
module nibble_add_arbiter
    import nibble_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int W     = DEFAULT_W
) (
    input logic                 clk,
    input logic                 reset,
    nibble_add_arbiter_if.slave bus
);

    localparam int ID_W = idWidth(N_REQ);

    arbStateT        state_q, state_d;
    logic [ID_W-1:0] rrPtr_q, rrPtr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [W-1:0]    aOp_q, aOp_d;
    logic [W-1:0]    bOp_q, bOp_d;
    logic [7:0]      opCount_q, opCount_d;

    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  winnerId;
    logic             winnerFound;
    logic [N_REQ-1:0] reqReady;
    logic             adderEn;
    logic [W:0]       sum;

    // N_REQ is a power of two, so wrapping the ID_W-bit add is the modulo rotation.
    always_comb begin
        cand        = '0;
        winnerId    = '0;
        winnerFound = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = rrPtr_q + ID_W'(k);
            if (!winnerFound && bus.req_valid[cand]) begin
                winnerFound = 1'b1;
                winnerId    = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            id_q      <= '0;
            aOp_q     <= '0;
            bOp_q     <= '0;
            opCount_q <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            id_q      <= id_d;
            aOp_q     <= aOp_d;
            bOp_q     <= bOp_d;
            opCount_q <= opCount_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        id_d      = id_q;
        aOp_d     = aOp_q;
        bOp_d     = bOp_q;
        opCount_d = opCount_q;
        reqReady  = '0;
        adderEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    reqReady[winnerId] = 1'b1;
                    id_d    = winnerId;
                    aOp_d   = bus.req_a[winnerId*W +: W];
                    bOp_d   = bus.req_b[winnerId*W +: W];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                adderEn = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                // The pointer only moves when a result is handed off, not at accept.
                if (bus.rsp_ready) begin
                    rrPtr_d   = id_q + 1'b1;
                    opCount_d = opCount_q + 8'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    nibble_adder_unit #(.W(W)) u_adder (
        .clk   (clk),
        .reset (reset),
        .en_i  (adderEn),
        .a_i   (aOp_q),
        .b_i   (bOp_q),
        .sum_o (sum)
    );

    assign bus.req_ready = reset ? '0 : reqReady;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum[W-1:0];
    assign bus.rsp_carry = sum[W];
    assign bus.op_count  = opCount_q;

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Self-checking bench for nibble_add_arbiter against a round-robin reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nibble_add_arbiter;
    import nibble_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   mPtr   = 0;
    int   mCount = 0;
    logic [W-1:0] opA [N];
    logic [W-1:0] opB [N];

    nibble_add_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    nibble_add_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference arbitration: first valid requester scanning upward from the pointer.
    function automatic int expWinner(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oneHot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = opA[i];
            bus.req_b[i*W +: W] = opB[i];
        end
        bus.req_valid = mask;
    endtask

    task automatic waitRsp(output int cyc);
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin opA[i] = '0; opB[i] = '0; end
        applyStimulus('0);
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %0h want 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_sum !== '0) begin errors++; $display("FAIL reset_rsp_sum got %0d want 0", bus.rsp_sum); end
        checks++; if (bus.rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_rsp_carry got %0b want 0", bus.rsp_carry); end
        checks++; if (bus.op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", bus.op_count); end
        reset = 1'b0;
        mPtr = 0;
        mCount = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        opA[1] = 4'd3;
        opB[1] = 4'd4;
        applyStimulus(4'b0010);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant got %b want 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin errors++; $display("FAIL single_exec got valid=%0b ready=%b want 0/0000", bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_latency got valid=%0b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_sum !== 4'd7 || bus.rsp_carry !== 1'b0) begin
            errors++; $display("FAIL single_result got id=%0d sum=%0d c=%0b want 1/7/0", bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        mPtr = 2;
        mCount = 1;
        checks++; if (bus.op_count !== 8'd1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_count got cnt=%0d valid=%0b want 1/0", bus.op_count, bus.rsp_valid); end
    endtask

    task automatic test_overflow();
        int req [2] = '{2, 3};
        int va  [2] = '{15, 8};
        int s, w;
        for (int n = 0; n < 2; n++) begin
            opA[req[n]] = W'(va[n]);
            opB[req[n]] = W'(va[n]);
            applyStimulus(oneHot(req[n]));
            w = expWinner(oneHot(req[n]), mPtr);
            s = va[n] + va[n];
            #1;
            checks++; if (bus.req_ready !== oneHot(w)) begin errors++; $display("FAIL ovf_grant got %b want %b", bus.req_ready, oneHot(w)); end
            @(negedge clk);
            bus.req_valid = '0;
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(w) || bus.rsp_sum !== W'(s % 16) || bus.rsp_carry !== 1'(s / 16)) begin
                errors++; $display("FAIL ovf_result got v=%0b id=%0d sum=%0d c=%0b want 1/%0d/%0d/%0d", bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, w, s % 16, s / 16);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            mPtr = (w + 1) % N;
            mCount++;
        end
        checks++; if (bus.op_count !== 8'(mCount)) begin errors++; $display("FAIL ovf_count got %0d want %0d", bus.op_count, mCount); end
    endtask

    task automatic test_round_robin();
        int cycle = 0, seen = 0, last = 0, e, s;
        for (int i = 0; i < N; i++) begin opA[i] = W'($urandom); opB[i] = W'($urandom); end
        applyStimulus(4'b1111);
        bus.rsp_ready = 1'b1;
        while (seen < 5 && cycle < 40) begin
            @(negedge clk);
            cycle++;
            if (bus.rsp_valid === 1'b1) begin
                e = expWinner(4'b1111, mPtr);
                s = int'(opA[e]) + int'(opB[e]);
                checks++; if (bus.rsp_id !== 2'(e) || bus.rsp_sum !== W'(s) || bus.rsp_carry !== 1'(s >> W)) begin
                    errors++; $display("FAIL rr_result got id=%0d sum=%0d c=%0b want %0d/%0d/%0d", bus.rsp_id, bus.rsp_sum, bus.rsp_carry, e, s % 16, s >> W);
                end
                if (seen > 0) begin
                    checks++; if (cycle - last != 3) begin errors++; $display("FAIL rr_spacing got %0d want 3", cycle - last); end
                end
                last = cycle;
                seen++;
                mPtr = (e + 1) % N;
                mCount++;
                if (seen == 5) bus.req_valid = '0;
            end
        end
        checks++; if (seen != 5) begin errors++; $display("FAIL rr_timeout got %0d responses want 5", seen); end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++; if (bus.op_count !== 8'(mCount) || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_count got %0d want %0d", bus.op_count, mCount); end
    endtask

    task automatic test_fairness();
        int cyc;
        logic [N-1:0] masks [3] = '{4'b0100, 4'b1001, 4'b0001};
        for (int n = 0; n < 3; n++) begin
            int w;
            if (n != 2) applyStimulus(masks[n]);
            w = expWinner(masks[n], mPtr);
            #1;
            checks++; if (bus.req_ready !== oneHot(w)) begin errors++; $display("FAIL fair_grant%0d got %b want %b", n, bus.req_ready, oneHot(w)); end
            @(negedge clk);
            bus.req_valid = masks[n] & ~oneHot(w);
            waitRsp(cyc);
            checks++; if (cyc >= 20 || bus.rsp_id !== 2'(w)) begin errors++; $display("FAIL fair_rsp%0d got id=%0d cyc=%0d want %0d", n, bus.rsp_id, cyc, w); end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            mPtr = (w + 1) % N;
            mCount++;
        end
    endtask

    task automatic test_backpressure();
        int w, s;
        for (int i = 0; i < N; i++) begin opA[i] = W'($urandom); opB[i] = W'($urandom); end
        applyStimulus(4'b1010);
        w = expWinner(4'b1010, mPtr);
        s = int'(opA[w]) + int'(opB[w]);
        #1;
        checks++; if (bus.req_ready !== oneHot(w)) begin errors++; $display("FAIL bp_grant got %b want %b", bus.req_ready, oneHot(w)); end
        @(negedge clk);
        bus.req_valid = 4'b1010 & ~oneHot(w);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(w) || bus.rsp_sum !== W'(s) || bus.rsp_carry !== 1'(s >> W) || bus.req_ready !== '0) begin
                errors++; $display("FAIL bp_hold%0d got v=%0b id=%0d sum=%0d c=%0b rdy=%b want 1/%0d/%0d/%0d/0000", k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.req_ready, w, s % 16, s >> W);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        mPtr = (w + 1) % N;
        mCount++;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.op_count !== 8'(mCount)) begin errors++; $display("FAIL bp_release got v=%0b cnt=%0d want 0/%0d", bus.rsp_valid, bus.op_count, mCount); end
        checks++; if (bus.req_ready !== oneHot(expWinner(bus.req_valid, mPtr))) begin errors++; $display("FAIL bp_next_grant got %b want %b", bus.req_ready, oneHot(expWinner(bus.req_valid, mPtr))); end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        opA[2] = 4'd9;
        opB[2] = 4'd9;
        applyStimulus(4'b0100);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_sum !== '0 || bus.rsp_carry !== 1'b0 || bus.op_count !== 8'd0) begin
            errors++; $display("FAIL midreset_outputs got rdy=%b v=%0b id=%0d sum=%0d c=%0b cnt=%0d want all 0", bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.op_count);
        end
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        mPtr = 0;
        mCount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0 || bus.op_count !== 8'd0) begin errors++; $display("FAIL midreset_quiet got v=%0b cnt=%0d want 0/0", bus.rsp_valid, bus.op_count); end
        end
        applyStimulus(4'b1111);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midreset_grant got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        waitRsp(cyc);
        checks++; if (cyc >= 20 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL midreset_rsp got id=%0d cyc=%0d want 0", bus.rsp_id, cyc); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        mPtr = 1;
        mCount = 1;
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int w, s, d;
        for (int n = 0; n < 30; n++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin opA[i] = W'($urandom); opB[i] = W'($urandom); end
            applyStimulus(mask);
            w = expWinner(mask, mPtr);
            s = int'(opA[w]) + int'(opB[w]);
            #1;
            checks++; if (bus.req_ready !== oneHot(w)) begin errors++; $display("FAIL rand_grant%0d got %b want %b", n, bus.req_ready, oneHot(w)); end
            @(negedge clk);
            bus.req_valid = '0;
            for (int i = 0; i < N; i++) begin opA[i] = W'($urandom); end
            applyStimulus('0);
            @(negedge clk);
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(w) || bus.rsp_sum !== W'(s) || bus.rsp_carry !== 1'(s >> W)) begin
                errors++; $display("FAIL rand_result%0d got v=%0b id=%0d sum=%0d c=%0b want 1/%0d/%0d/%0d", n, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, w, s % 16, s >> W);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            mPtr = (w + 1) % N;
            mCount = (mCount + 1) % 256;
            checks++; if (bus.op_count !== 8'(mCount) || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rand_count%0d got %0d want %0d", n, bus.op_count, mCount); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
